// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin controller for a 4 x 8 memory array.
// Each granted access drives the array for exactly one cycle (GRANT), then
// returns a one-cycle acknowledge to the owner (ACK). Reads land in rdata.
module mem_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACK
  } state_t;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;      // requester favoured on a tie
  logic                owner_q, owner_d;  // requester of the access in flight
  logic                cmd_rw_q, cmd_rw_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                win;

  // State, arbitration and command registers; async reset aborts any access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      cmd_rw_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cmd_rw_q    <= cmd_rw_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state logic and all outputs; array signals are zero outside GRANT.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cmd_rw_d    = cmd_rw_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata_d     = rdata_q;
    win         = 1'b0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    busy        = 1'b0;
    mem_en      = 1'b0;
    mem_rw      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // A lone requester wins outright; on a tie the pointer decides.
          win         = (req0 && req1) ? ptr_q : req1;
          owner_d     = win;
          ptr_d       = ~win;
          cmd_rw_d    = win ? rw1    : rw0;
          cmd_addr_d  = win ? addr1  : addr0;
          cmd_wdata_d = win ? wdata1 : wdata0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_rw    = cmd_rw_q;
        mem_addr  = cmd_addr_q;
        mem_wdata = cmd_wdata_q;
        if (!cmd_rw_q) begin
          rdata_d = mem_rdata;
        end
        state_d = ACK;
      end
      ACK: begin
        busy    = 1'b1;
        ack0    = ~owner_q;
        ack1    = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural 4 x 8 array and a
// transaction-level reference model (memory image, last-served requester).
module tb_mem_arbiter;

  logic       clk;
  logic       reset;
  logic       req0, req1, rw0, rw1;
  logic [1:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, busy, mem_en, mem_rw;
  logic [7:0] rdata, mem_wdata, mem_rdata;
  logic [1:0] mem_addr;

  // Array attached to the arbiter, and its preload image.
  logic [7:0] arr [4];
  logic [7:0] init_val [4];
  logic       preload;

  // Reference model state.
  logic [7:0] ref_mem [4];
  logic [7:0] exp_rdata;
  bit         last_winner;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4; i++) arr[i] <= init_val[i];
    end else if (mem_en && mem_rw) begin
      arr[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = arr[mem_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_cmd(input int unsigned which);
    if (which == 0) begin
      rw0 = 1'($urandom_range(0, 1)); addr0 = 2'($urandom); wdata0 = 8'($urandom);
    end else begin
      rw1 = 1'($urandom_range(0, 1)); addr1 = 2'($urandom); wdata1 = 8'($urandom);
    end
  endtask

  // One access from IDLE: sample edge, GRANT cycle, ACK cycle, back to IDLE.
  // The winner drops req after its ack; a losing requester keeps requesting.
  task automatic txn();
    bit         win, w;
    logic [1:0] a;
    logic [7:0] d;
    if (!req0 && !req1) begin
      chk("txn_no_request", 0, 1);
      return;
    end
    win = (req0 && req1) ? !last_winner : req1;
    last_winner = win;
    w = win ? rw1 : rw0;
    a = win ? addr1 : addr0;
    d = win ? wdata1 : wdata0;
    @(posedge clk);
    @(negedge clk);
    chk("grant_en", mem_en, 1);
    chk("grant_rw", mem_rw, w);
    chk("grant_addr", mem_addr, a);
    chk("grant_wdata", mem_wdata, d);
    chk("grant_busy", busy, 1);
    chk("grant_noack", {ack1, ack0}, 0);
    // Command inputs moving after the grant edge must not disturb the access.
    if (win) begin addr1 = 2'($urandom); wdata1 = 8'($urandom); end
    else     begin addr0 = 2'($urandom); wdata0 = 8'($urandom); end
    @(posedge clk);
    if (w) ref_mem[a] = d;
    else   exp_rdata = ref_mem[a];
    @(negedge clk);
    chk("ack_vec", {ack1, ack0}, win ? 2'b10 : 2'b01);
    chk("ack_rdata", rdata, exp_rdata);
    chk("ack_en", {mem_en, mem_rw}, 0);
    chk("ack_busy", busy, 1);
    @(posedge clk);
    #1;
    if (win) req1 = 1'b0; else req0 = 1'b0;
    chk("idle_after", {busy, ack1, ack0}, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      init_val[i] = 8'($urandom);
      ref_mem[i]  = init_val[i];
    end
    init_val[2] = 8'h7F;
    ref_mem[2]  = 8'h7F;
    preload = 1'b1;
    reset = 1'b1;
    req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    exp_rdata = '0;
    last_winner = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {ack0, ack1, busy, mem_en, mem_rw}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk);
    preload = 1'b0;
    reset = 1'b0;

    // Contention straight out of reset: requester 0 first, then 1.
    rw0 = 1; addr0 = 2'd0; wdata0 = 8'h3C;
    rw1 = 1; addr1 = 2'd1; wdata1 = 8'h99;
    req0 = 1; req1 = 1;
    txn();
    txn();

    // Single write then read back.
    rw0 = 1; addr0 = 2'b01; wdata0 = 8'h25; req0 = 1;
    txn();
    rw0 = 0; addr0 = 2'b01; req0 = 1;
    txn();
    chk("rd_25", rdata, 8'h25);

    // Isolation: req1 writes addr 3 while req0 reads addr 2.
    rw1 = 1; addr1 = 2'b11; wdata1 = 8'h57; req1 = 1;
    rw0 = 0; addr0 = 2'b10; req0 = 1;
    txn();
    txn();
    chk("iso_rd_7f", rdata, 8'h7F);
    rw0 = 0; addr0 = 2'b11; req0 = 1;
    txn();
    chk("iso_rd_57", rdata, 8'h57);

    // Idle hygiene.
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("idle_en", {mem_en, mem_rw}, 0);
      chk("idle_rdata", rdata, exp_rdata);
    end
    for (int i = 0; i < 4; i++) chk("idle_array", arr[i], ref_mem[i]);

    // Withdrawn request: pulse between edges, never sampled.
    #2 req1 = 1;
    #2 req1 = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("wd_quiet", {mem_en, ack1, busy}, 0);
    end

    // Reset in the middle of a read granted to requester 0.
    rw0 = 0; addr0 = 2'b10; req0 = 1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_grant", mem_en, 1);
    reset = 1;
    #1;
    chk("mid_rst_outs", {ack0, mem_en, busy}, 0);
    chk("mid_rst_rdata", rdata, 0);
    req0 = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    exp_rdata = '0;
    last_winner = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("post_rst_quiet", {ack0, ack1, mem_en}, 0);
    end
    // Pointer back at requester 0 after reset.
    new_cmd(0); new_cmd(1);
    req0 = 1; req1 = 1;
    txn();
    txn();

    // Both requesters held continuously: strict alternation.
    for (int k = 0; k < 6; k++) begin
      bit prev;
      prev = last_winner;
      if (!req0) begin new_cmd(0); req0 = 1; end
      if (!req1) begin new_cmd(1); req1 = 1; end
      txn();
      chk("alternate", last_winner, !prev);
    end
    req0 = 0; req1 = 0;

    // Randomized traffic.
    for (int t = 0; t < 50; t++) begin
      if (!req0 && $urandom_range(0, 1) == 1) begin new_cmd(0); req0 = 1; end
      if (!req1 && $urandom_range(0, 1) == 1) begin new_cmd(1); req1 = 1; end
      if (!req0 && !req1) begin
        @(posedge clk);
        #1;
        chk("rnd_idle", {mem_en, ack0, ack1}, 0);
      end else begin
        txn();
      end
    end
    req0 = 0; req1 = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk("final_array", arr[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
